// File: rtl/switch_input_reader.sv
// Synchronizes and debounces slide switches and push buttons, then captures an
// operand pair from the switches under button control for a downstream consumer.
module switch_input_reader #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] SW,
    input  logic [3:0] BTN,
    output logic [7:0] sw_stable,
    output logic       sw_changed,
    output logic [3:0] btn_level,
    output logic [3:0] btn_press,
    output logic [3:0] btn_release,
    output logic [7:0] op_a,
    output logic [7:0] op_b,
    output logic       op_valid,
    input  logic       op_ack
);

    localparam int NBITS = 12;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Switches occupy bits 7:0 and buttons bits 11:8 of every per-bit vector.
    logic [NBITS-1:0] s1;
    logic [NBITS-1:0] s2;
    logic [NBITS-1:0] stable;
    logic [NBITS-1:0] stable_next;
    logic [CNT_W-1:0] cnt      [NBITS];
    logic [CNT_W-1:0] cnt_next [NBITS];

    always_comb begin
        stable_next = stable;
        for (int i = 0; i < NBITS; i++) begin
            cnt_next[i] = '0;
            if (s2[i] != stable[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    stable_next[i] = s2[i];
                end else begin
                    cnt_next[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1          <= '0;
            s2          <= '0;
            stable      <= '0;
            sw_changed  <= 1'b0;
            btn_press   <= '0;
            btn_release <= '0;
            for (int i = 0; i < NBITS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1          <= {BTN, SW};
            s2          <= s1;
            stable      <= stable_next;
            sw_changed  <= |(stable_next[7:0] ^ stable[7:0]);
            btn_press   <= stable_next[11:8] & ~stable[11:8];
            btn_release <= ~stable_next[11:8] & stable[11:8];
            for (int i = 0; i < NBITS; i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

    assign sw_stable = stable[7:0];
    assign btn_level = stable[11:8];

    // Handshake: op_valid rises once the pair is submitted and stays high with
    // op_a/op_b frozen until op_ack is seen high at a clock edge while op_valid=1;
    // op_valid falls at that edge. op_ack while op_valid=0 has no effect.
    state_t state;
    state_t state_next;
    logic   load_a;
    logic   load_b;
    logic   clear_ops;

    always_comb begin
        state_next = state;
        load_a     = 1'b0;
        load_b     = 1'b0;
        clear_ops  = 1'b0;
        if (btn_press[3]) begin
            clear_ops  = 1'b1;
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    load_a = btn_press[0];
                    load_b = btn_press[1];
                    if (btn_press[2]) state_next = HOLD;
                end
                HOLD: begin
                    if (op_ack) state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            op_valid <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
        end else begin
            state    <= state_next;
            op_valid <= (state_next == HOLD);
            if (clear_ops) begin
                op_a <= '0;
                op_b <= '0;
            end else begin
                if (load_a) op_a <= sw_stable;
                if (load_b) op_b <= sw_stable;
            end
        end
    end

endmodule

// File: tb/tb_switch_input_reader.sv
// Directed bench for switch_input_reader with a short debounce window of 4 clocks.
module tb_switch_input_reader;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] SW;
    logic [3:0] BTN;
    logic [7:0] sw_stable;
    logic       sw_changed;
    logic [3:0] btn_level;
    logic [3:0] btn_press;
    logic [3:0] btn_release;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       op_valid;
    logic       op_ack;

    int compared   = 0;
    int mismatched = 0;

    logic [3:0] acc_press;
    logic [3:0] acc_rel;
    logic       acc_chg;

    switch_input_reader #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W(16)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .SW(SW),
        .BTN(BTN),
        .sw_stable(sw_stable),
        .sw_changed(sw_changed),
        .btn_level(btn_level),
        .btn_press(btn_press),
        .btn_release(btn_release),
        .op_a(op_a),
        .op_b(op_b),
        .op_valid(op_valid),
        .op_ack(op_ack)
    );

    always #5 CLK = ~CLK;

    // One clock edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_acc();
        acc_press = '0;
        acc_rel   = '0;
        acc_chg   = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            acc_press = acc_press | btn_press;
            acc_rel   = acc_rel | btn_release;
            acc_chg   = acc_chg | sw_changed;
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        RST    = 1'b1;
        SW     = 8'h00;
        BTN    = 4'h0;
        op_ack = 1'b0;
        clear_acc();
        step();
        step();
        check("rst_sw_stable", sw_stable, 8'h00);
        check("rst_sw_changed", {7'd0, sw_changed}, 8'h00);
        check("rst_btn_level", {4'd0, btn_level}, 8'h00);
        check("rst_op_valid", {7'd0, op_valid}, 8'h00);
        check("rst_op_a", op_a, 8'h00);
        check("rst_op_b", op_b, 8'h00);
        RST = 1'b0;
        run(2);

        // Switch change: visible 5 edges after the first edge that sees it.
        SW = 8'h11;
        clear_acc();
        run(5);
        check("sw_early_stable", sw_stable, 8'h00);
        check("sw_early_changed", {7'd0, acc_chg}, 8'h00);
        step();
        check("sw_update_stable", sw_stable, 8'h11);
        check("sw_update_changed", {7'd0, sw_changed}, 8'h01);
        step();
        check("sw_changed_drop", {7'd0, sw_changed}, 8'h00);

        // Bouncing BTN[0]: high 2, low 1, then held high.
        clear_acc();
        BTN = 4'h1;
        run(2);
        BTN = 4'h0;
        run(1);
        BTN = 4'h1;
        run(5);
        check("bounce_no_press", {4'd0, acc_press}, 8'h00);
        check("bounce_level_low", {4'd0, btn_level}, 8'h00);
        step();
        check("bounce_press", {4'd0, btn_press}, 8'h01);
        check("bounce_level_high", {4'd0, btn_level}, 8'h01);
        step();
        check("press_drop", {4'd0, btn_press}, 8'h00);
        check("load_a", op_a, 8'h11);
        clear_acc();
        BTN = 4'h0;
        run(5);
        check("release_early", {4'd0, acc_rel}, 8'h00);
        step();
        check("release_pulse", {4'd0, btn_release}, 8'h01);
        check("release_level", {4'd0, btn_level}, 8'h00);
        step();
        check("release_drop", {4'd0, btn_release}, 8'h00);

        // Load B with 0x22 then submit.
        SW = 8'h22;
        run(6);
        check("sw_22", sw_stable, 8'h22);
        BTN = 4'h2;
        run(6);
        check("press_b", {4'd0, btn_press}, 8'h02);
        step();
        check("load_b", op_b, 8'h22);
        check("load_b_keeps_a", op_a, 8'h11);
        BTN = 4'h0;
        run(6);
        BTN = 4'h4;
        run(6);
        check("press_submit", {4'd0, btn_press}, 8'h04);
        check("submit_not_yet", {7'd0, op_valid}, 8'h00);
        step();
        check("submit_valid", {7'd0, op_valid}, 8'h01);
        check("submit_a", op_a, 8'h11);
        check("submit_b", op_b, 8'h22);
        BTN = 4'h0;
        run(6);

        // HOLD ignores loads; ack releases; ack in IDLE is ignored.
        SW = 8'h33;
        run(6);
        BTN = 4'h1;
        run(6);
        check("hold_press_a", {4'd0, btn_press}, 8'h01);
        step();
        check("hold_frozen_a", op_a, 8'h11);
        check("hold_still_valid", {7'd0, op_valid}, 8'h01);
        BTN = 4'h0;
        run(6);
        op_ack = 1'b1;
        step();
        op_ack = 1'b0;
        check("ack_valid_drop", {7'd0, op_valid}, 8'h00);
        check("ack_keeps_a", op_a, 8'h11);
        op_ack = 1'b1;
        step();
        op_ack = 1'b0;
        step();
        check("idle_ack_valid", {7'd0, op_valid}, 8'h00);
        check("idle_ack_a", op_a, 8'h11);
        check("idle_ack_b", op_b, 8'h22);

        // Re-enter HOLD, then clear together with ack.
        BTN = 4'h4;
        run(6);
        step();
        check("rehold_valid", {7'd0, op_valid}, 8'h01);
        BTN = 4'h0;
        run(6);
        BTN = 4'h8;
        run(6);
        check("press_clear", {4'd0, btn_press}, 8'h08);
        op_ack = 1'b1;
        step();
        op_ack = 1'b0;
        check("clear_a", op_a, 8'h00);
        check("clear_b", op_b, 8'h00);
        check("clear_valid", {7'd0, op_valid}, 8'h00);
        BTN = 4'h0;
        run(6);

        // Simultaneous A and B loads.
        SW = 8'h5A;
        run(6);
        BTN = 4'h3;
        run(6);
        check("press_ab", {4'd0, btn_press}, 8'h03);
        step();
        check("both_a", op_a, 8'h5A);
        check("both_b", op_b, 8'h5A);
        check("both_idle", {7'd0, op_valid}, 8'h00);
        BTN = 4'h0;
        run(6);

        // Reset mid-debounce with BTN[2] held.
        clear_acc();
        BTN = 4'h4;
        run(3);
        RST = 1'b1;
        run(2);
        check("midrst_no_pulse", {4'd0, acc_press}, 8'h00);
        check("midrst_level", {4'd0, btn_level}, 8'h00);
        check("midrst_op_a", op_a, 8'h00);
        check("midrst_sw", sw_stable, 8'h00);
        RST = 1'b0;
        clear_acc();
        run(5);
        check("post_rst_early", {4'd0, acc_press}, 8'h00);
        step();
        check("post_rst_press", {4'd0, btn_press}, 8'h04);
        check("post_rst_sw_changed", {7'd0, sw_changed}, 8'h01);
        check("post_rst_sw", sw_stable, 8'h5A);
        check("post_rst_not_valid", {7'd0, op_valid}, 8'h00);
        step();
        check("post_rst_valid", {7'd0, op_valid}, 8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
